// File: rtl/nn_layer_sequencer.sv
// Sequences a chain of network layers through a start/done handshake and
// reports completion or a per-layer watchdog timeout on a valid/ready result port.
module nn_layer_sequencer #(
    parameter int NUM_LAYERS = 3,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 16,
    parameter int IDX_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run_valid,
    output logic                  run_ready,
    output logic [NUM_LAYERS-1:0] layer_start,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic                  busy,
    output logic [IDX_W-1:0]      cur_layer,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  result_error,
    output logic [IDX_W-1:0]      err_layer,
    output logic [CNT_W-1:0]      cycle_count
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_LAYER = IDX_W'(NUM_LAYERS - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT   = WD_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESULT,
        S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cur_q, cur_d;
    logic [IDX_W-1:0] err_layer_q, err_layer_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             done_sel;
    logic [WD_W-1:0]  wd_next;
    logic [CNT_W-1:0] cnt_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            err_layer_q <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            err_layer_q <= err_layer_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
        end
    end

    // Only the done bit of the layer currently being run is ever looked at.
    always_comb begin
        done_sel = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (cur_q == IDX_W'(i)) begin
                done_sel = layer_done[i];
            end
        end
    end

    assign wd_next = wd_q + WD_W'(1);
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        err_layer_d = err_layer_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        wd_d        = wd_q;

        case (state_q)
            S_IDLE: begin
                if (run_valid && !rst) begin
                    state_d     = S_LAUNCH;
                    cur_d       = '0;
                    cnt_d       = '0;
                    err_d       = 1'b0;
                    err_layer_d = '0;
                end
            end
            S_LAUNCH: begin
                wd_d    = '0;
                cnt_d   = cnt_inc;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done landing on the final watchdog cycle still wins.
                cnt_d = cnt_inc;
                wd_d  = wd_next;
                if (done_sel) begin
                    if (cur_q == LAST_LAYER) begin
                        state_d = S_RESULT;
                    end else begin
                        cur_d   = cur_q + IDX_W'(1);
                        state_d = S_LAUNCH;
                    end
                end else if (wd_next == WD_LIMIT) begin
                    state_d     = S_ERROR;
                    err_layer_d = cur_q;
                    err_d       = 1'b1;
                end
            end
            S_RESULT, S_ERROR: begin
                if (result_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        layer_start = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            layer_start[i] = (state_q == S_LAUNCH) && (cur_q == IDX_W'(i));
        end
    end

    assign run_ready    = (state_q == S_IDLE) && !rst;
    assign busy         = (state_q != S_IDLE);
    assign result_valid = (state_q == S_RESULT) || (state_q == S_ERROR);
    assign cur_layer    = cur_q;
    assign result_error = err_q;
    assign err_layer    = err_layer_q;
    assign cycle_count  = cnt_q;

endmodule
